// File: rtl/coin_start_seq.sv
// coin_start_seq: turns a start press into frame-timed coin, gap and start pulses
module coin_start_seq #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 8,
  parameter int START_FRAMES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic I_VBLANK,
  input  logic I_START1,
  input  logic I_START2,
  output logic O_COIN,
  output logic O_START1,
  output logic O_START2,
  output logic O_BUSY
);
  typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} state_t;
  localparam logic [7:0] COIN_LAST  = 8'(COIN_FRAMES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);
  state_t state, nxt;
  logic [7:0] cnt;
  logic [1:0] sel, sel_nxt;
  logic vblank_d, start1_d, start2_d;
  logic tick, p1, p2;
  assign tick = I_VBLANK & ~vblank_d;
  assign p1   = I_START1 & ~start1_d;
  assign p2   = I_START2 & ~start2_d;
  // state, selection, frame counter and edge-detect history
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      sel      <= 2'd0;
      cnt      <= 8'd0;
      vblank_d <= 1'b1;
      start1_d <= 1'b1;
      start2_d <= 1'b1;
    end else begin
      state    <= nxt;
      sel      <= sel_nxt;
      cnt      <= (nxt != state) ? 8'd0 :
                  (tick && state inside {COIN, GAP, START}) ? cnt + 8'd1 : cnt;
      vblank_d <= I_VBLANK;
      start1_d <= I_START1;
      start2_d <= I_START2;
    end
  end
  // next state: 1P wins a tie; phases advance on the frame tick that completes them
  always_comb begin
    nxt     = state;
    sel_nxt = sel;
    case (state)
      IDLE: begin
        if (p1) begin
          nxt     = COIN;
          sel_nxt = 2'd1;
        end else if (p2) begin
          nxt     = COIN;
          sel_nxt = 2'd2;
        end
      end
      COIN:    nxt = (tick && cnt == COIN_LAST) ? GAP : COIN;
      GAP:     nxt = (tick && cnt == GAP_LAST) ? START : GAP;
      START:   nxt = (tick && cnt == START_LAST) ? RELEASE : START;
      RELEASE: nxt = (!I_START1 && !I_START2) ? IDLE : RELEASE;
      default: nxt = IDLE;
    endcase
  end
  // outputs registered from the next state so they switch with the transition
  always_ff @(posedge CLK) begin
    if (RESET) begin
      O_COIN   <= 1'b0;
      O_START1 <= 1'b0;
      O_START2 <= 1'b0;
      O_BUSY   <= 1'b0;
    end else begin
      O_COIN   <= nxt == COIN;
      O_START1 <= nxt == START && sel_nxt == 2'd1;
      O_START2 <= nxt == START && sel_nxt == 2'd2;
      O_BUSY   <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_coin_start_seq.sv
// tb_coin_start_seq: vectors, corner sequences and random stimulus against a frame-level model
module tb_coin_start_seq;
  logic CLK = 1'b0;
  logic RESET = 1'b1, I_VBLANK = 1'b0, I_START1 = 1'b0, I_START2 = 1'b0;
  logic c [3];
  logic a [3];
  logic b [3];
  logic y [3];
  int checks = 0, errors = 0;
  int durs [3][3] = '{'{4, 8, 4}, '{1, 1, 1}, '{255, 1, 1}};
  typedef struct {int ph; int left; int who; bit pvb; bit ps1; bit ps2;} mdl_t;
  mdl_t m [3];
  typedef struct {bit r; bit vb; bit s1; bit s2; logic [3:0] e;} vec_t;
  vec_t tv [16];
  bit tb_pvb = 1'b1;
  int vph = 0;
  int coin_t [3], st1_t [3], st2_t [3], ovl;

  always #5 CLK = ~CLK;

  coin_start_seq u0 (.CLK(CLK), .RESET(RESET), .I_VBLANK(I_VBLANK), .I_START1(I_START1),
    .I_START2(I_START2), .O_COIN(c[0]), .O_START1(a[0]), .O_START2(b[0]), .O_BUSY(y[0]));
  coin_start_seq #(.COIN_FRAMES(1), .GAP_FRAMES(1), .START_FRAMES(1)) u1 (.CLK(CLK),
    .RESET(RESET), .I_VBLANK(I_VBLANK), .I_START1(I_START1), .I_START2(I_START2),
    .O_COIN(c[1]), .O_START1(a[1]), .O_START2(b[1]), .O_BUSY(y[1]));
  coin_start_seq #(.COIN_FRAMES(255), .GAP_FRAMES(1), .START_FRAMES(1)) u2 (.CLK(CLK),
    .RESET(RESET), .I_VBLANK(I_VBLANK), .I_START1(I_START1), .I_START2(I_START2),
    .O_COIN(c[2]), .O_START1(a[2]), .O_START2(b[2]), .O_BUSY(y[2]));

  function automatic logic [3:0] ov(int i);
    return {c[i], a[i], b[i], y[i]};
  endfunction

  // phases: 0 idle, 1 coin, 2 gap, 3 start, 4 waiting for buttons up
  function automatic void mstep(int i, bit r, bit vb, bit s1, bit s2);
    bit tk, e1, e2;
    if (r) begin
      m[i] = '{0, 0, 0, 1'b1, 1'b1, 1'b1};
      return;
    end
    tk = vb && !m[i].pvb;
    e1 = s1 && !m[i].ps1;
    e2 = s2 && !m[i].ps2;
    if (m[i].ph == 0) begin
      if (e1 || e2) begin
        m[i].who  = e1 ? 1 : 2;
        m[i].ph   = 1;
        m[i].left = durs[i][0];
      end
    end else if (m[i].ph < 4) begin
      if (tk) begin
        m[i].left--;
        if (m[i].left == 0) begin
          m[i].ph++;
          if (m[i].ph < 4) m[i].left = durs[i][m[i].ph - 1];
        end
      end
    end else if (!s1 && !s2) m[i].ph = 0;
    m[i].pvb = vb;
    m[i].ps1 = s1;
    m[i].ps2 = s2;
  endfunction

  function automatic logic [3:0] mexp(int i);
    return {m[i].ph == 1, m[i].ph == 3 && m[i].who == 1, m[i].ph == 3 && m[i].who == 2, m[i].ph != 0};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(bit r, bit vb, bit s1, bit s2);
    bit tk;
    logic [3:0] pre [3];
    RESET = r;
    I_VBLANK = vb;
    I_START1 = s1;
    I_START2 = s2;
    tk = vb && !tb_pvb;
    tb_pvb = r ? 1'b1 : vb;
    for (int i = 0; i < 3; i++) begin
      pre[i] = ov(i);
      if (tk && !r) begin
        if (pre[i][3]) coin_t[i]++;
        if (pre[i][2]) st1_t[i]++;
        if (pre[i][1]) st2_t[i]++;
      end
    end
    @(posedge CLK);
    for (int i = 0; i < 3; i++) mstep(i, r, vb, s1, s2);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_u%0d", i), {28'd0, ov(i)}, {28'd0, mexp(i)});
      if ((c[i] && (a[i] || b[i])) || (a[i] && b[i])) ovl++;
    end
  endtask

  task automatic fcyc(bit r, bit s1, bit s2);
    cyc(r, (vph % 4) >= 2, s1, s2);
    vph++;
  endtask

  task automatic run_seq(bit p1, bit p2, bit hold2, int midpress, int n);
    for (int i = 0; i < 3; i++) begin
      coin_t[i] = 0;
      st1_t[i] = 0;
      st2_t[i] = 0;
    end
    for (int k = 0; k < n; k++)
      fcyc(1'b0, (p1 && k < 2) || (midpress >= 0 && k >= midpress && k < midpress + 2),
           p2 && (hold2 || k < 2));
  endtask

  initial begin
    tv[0]  = '{1, 1, 1, 0, 4'b0000};
    tv[1]  = '{1, 1, 1, 0, 4'b0000};
    tv[2]  = '{0, 1, 1, 0, 4'b0000};
    tv[3]  = '{0, 0, 1, 0, 4'b0000};
    tv[4]  = '{0, 1, 1, 0, 4'b0000};
    tv[5]  = '{0, 1, 0, 0, 4'b0000};
    tv[6]  = '{0, 0, 1, 0, 4'b1001};
    tv[7]  = '{0, 1, 1, 0, 4'b1001};
    tv[8]  = '{0, 1, 0, 0, 4'b1001};
    tv[9]  = '{0, 0, 0, 1, 4'b1001};
    tv[10] = '{0, 1, 0, 0, 4'b1001};
    tv[11] = '{0, 0, 0, 0, 4'b1001};
    tv[12] = '{0, 1, 0, 0, 4'b1001};
    tv[13] = '{0, 0, 0, 0, 4'b1001};
    tv[14] = '{0, 1, 0, 0, 4'b0001};
    tv[15] = '{1, 1, 0, 0, 4'b0000};
    ovl = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(tv[k].r, tv[k].vb, tv[k].s1, tv[k].s2);
      chk($sformatf("vec%0d", k), {28'd0, ov(0)}, {28'd0, tv[k].e});
    end
    // reset hygiene with start held across release
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) fcyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) chk($sformatf("hygiene_u%0d", i), {28'd0, ov(i)}, 32'd0);
    fcyc(1'b0, 1'b0, 1'b0);
    // 1P sequence on all three parameter sets
    run_seq(1, 0, 0, -1, 1100);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p1_coin_u%0d", i), coin_t[i], durs[i][0]);
      chk($sformatf("p1_st1_u%0d", i), st1_t[i], durs[i][2]);
      chk($sformatf("p1_st2_u%0d", i), st2_t[i], 0);
      chk($sformatf("p1_idle_u%0d", i), {31'd0, y[i]}, 0);
    end
    // simultaneous press: 1P wins
    run_seq(1, 1, 0, -1, 1100);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tie_st1_u%0d", i), st1_t[i], durs[i][2]);
      chk($sformatf("tie_st2_u%0d", i), st2_t[i], 0);
    end
    // 2P alone
    run_seq(0, 1, 0, -1, 1100);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p2_st1_u%0d", i), st1_t[i], 0);
      chk($sformatf("p2_st2_u%0d", i), st2_t[i], durs[i][2]);
    end
    // held button waits, release frees, re-press restarts
    run_seq(0, 1, 1, -1, 1100);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("held_coin_u%0d", i), coin_t[i], durs[i][0]);
      chk($sformatf("held_busy_u%0d", i), {31'd0, y[i]}, 1);
    end
    fcyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk($sformatf("held_drop_u%0d", i), {31'd0, y[i]}, 0);
    run_seq(0, 1, 0, -1, 1100);
    for (int i = 0; i < 3; i++) chk($sformatf("repress_st2_u%0d", i), st2_t[i], durs[i][2]);
    // press during gap (u0) and during the long coin (u2) is ignored
    run_seq(1, 0, 0, 30, 1100);
    chk("busy_ign_coin_u0", coin_t[0], 4);
    chk("busy_ign_st1_u0", st1_t[0], 4);
    chk("busy_ign_coin_u2", coin_t[2], 255);
    // reset during start drops everything at once
    begin
      bit seen = 0;
      fcyc(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 300 && !seen; k++) begin
        fcyc(1'b0, 1'b0, 1'b0);
        seen = a[0];
      end
      chk("reach_start_u0", {31'd0, seen}, 1);
      fcyc(1'b1, 1'b0, 1'b0);
      chk("rst_mid_u0", {28'd0, ov(0)}, 0);
      fcyc(1'b0, 1'b0, 1'b0);
    end
    // randomized traffic
    begin
      bit vb = 0, s1 = 0, s2 = 0;
      int per = 4, ph = 0;
      for (int k = 0; k < 5000; k++) begin
        if (++ph >= per) begin
          ph = 0;
          vb = ~vb;
          per = int'($urandom_range(1, 6));
        end
        if ($urandom_range(0, 39) == 0) s1 = ~s1;
        if ($urandom_range(0, 59) == 0) s2 = ~s2;
        cyc($urandom_range(0, 399) == 0, vb, s1, s2);
      end
    end
    chk("no_overlap", ovl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
